// File: rtl/moore_step_counter.sv
// Modulo-MOD state counter advanced by a DIV-cycle prescaler, with a
// seven-segment (active-low) decode of the current state.
module moore_step_counter #(
  parameter int unsigned DIV  = 25000000,
  parameter int unsigned MOD  = 6,
  parameter int unsigned STEP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] state,
  output logic [6:0] seg,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_JUMP = 2'b10,
    MODE_DEC  = 2'b11
  } mode_t;

  localparam logic [31:0] LAST   = 32'(DIV - 1);
  localparam logic [4:0]  MOD_W  = 5'(MOD);
  localparam logic [4:0]  STEP_W = 5'(STEP);
  localparam logic [3:0]  TOP    = 4'(MOD - 1);

  logic [31:0] count;
  logic        expire;
  mode_t       step_mode;
  logic [4:0]  sum;
  logic [3:0]  next_state;
  logic        step_wrap;

  assign expire    = en && (count == LAST);
  assign step_mode = mode_t'(mode);

  // Up steps never exceed 2*MOD-2, so a single conditional subtract is a full modulo.
  always_comb begin
    sum        = {1'b0, state};
    next_state = state;
    step_wrap  = 1'b0;
    case (step_mode)
      MODE_INC:  sum = {1'b0, state} + 5'd1;
      MODE_JUMP: sum = {1'b0, state} + STEP_W;
      default:   sum = {1'b0, state};
    endcase
    if (sum >= MOD_W) sum = sum - MOD_W;
    case (step_mode)
      MODE_INC, MODE_JUMP: begin
        next_state = sum[3:0];
        step_wrap  = (sum[3:0] < state);
      end
      MODE_DEC: begin
        if (state == 4'd0) begin
          next_state = TOP;
          step_wrap  = 1'b1;
        end else begin
          next_state = state - 4'd1;
        end
      end
      default: begin
        next_state = state;
        step_wrap  = 1'b0;
      end
    endcase
  end

  // A load wins over any step and restarts the prescaler from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      state <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= '0;
      state <= ({1'b0, load_val} >= MOD_W) ? TOP : load_val;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      tick <= expire;
      wrap <= expire && step_wrap;
      if (en) count <= expire ? '0 : count + 32'd1;
      if (expire) state <= next_state;
    end
  end

  always_comb begin
    seg = 7'b1111111;
    case (state)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_moore_step_counter.sv
// Directed bench for moore_step_counter: a DIV=4/MOD=6 instance for stepping
// behaviour and a DIV=4/MOD=16 instance for the full segment sweep.
module tb_moore_step_counter;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] state;
  logic [6:0] seg;
  logic       tick;
  logic       wrap;

  logic       reset16 = 1'b0;
  logic [3:0] state16;
  logic [6:0] seg16;
  logic       tick16;
  logic       wrap16;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  moore_step_counter #(.DIV(4), .MOD(6), .STEP(3)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .state(state), .seg(seg), .tick(tick), .wrap(wrap)
  );

  moore_step_counter #(.DIV(4), .MOD(16), .STEP(3)) dut16 (
    .clk(clk), .reset(reset16), .en(1'b1), .mode(2'b01), .load(1'b0),
    .load_val(4'd0), .state(state16), .seg(seg16), .tick(tick16), .wrap(wrap16)
  );

  task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_state,
                             input logic exp_tick, input logic exp_wrap);
    checkVal({tag, ".state"}, {4'd0, state}, {4'd0, exp_state});
    checkVal({tag, ".tick"}, {7'd0, tick}, {7'd0, exp_tick});
    checkVal({tag, ".wrap"}, {7'd0, wrap}, {7'd0, exp_wrap});
    checkVal({tag, ".seg"}, {1'b0, seg}, {1'b0, SEG_TABLE[exp_state]});
  endtask

  task automatic applyStimulus(input logic new_en, input logic [1:0] new_mode,
                               input logic new_load, input logic [3:0] new_val);
    en       = new_en;
    mode     = new_mode;
    load     = new_load;
    load_val = new_val;
  endtask

  // Each step lands 1 time unit after the rising edge, away from the active edge.
  task automatic stepClocks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0] inc_seq [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};

    #2;
    checkOutput("reset_state", 4'd0, 1'b0, 1'b0);
    stepClocks(2);
    reset = 1'b1;
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd0);

    // Increment run: tick every 4th cycle, wrap only on 5->0
    for (int k = 0; k < 7; k++) begin
      stepClocks(3);
      checkVal($sformatf("inc%0d.idle_tick", k), {7'd0, tick}, 8'd0);
      stepClocks(1);
      checkOutput($sformatf("inc%0d", k), inc_seq[k], 1'b1, (k == 5));
    end

    // Jump by STEP from 4
    applyStimulus(1'b1, 2'b10, 1'b1, 4'd4);
    stepClocks(1);
    checkOutput("load4", 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 4'd0);
    stepClocks(4);
    checkOutput("jump_4to1", 4'd1, 1'b1, 1'b1);
    stepClocks(4);
    checkOutput("jump_1to4", 4'd4, 1'b1, 1'b0);

    // Decrement from 0 wraps to MOD-1
    applyStimulus(1'b1, 2'b11, 1'b1, 4'd0);
    stepClocks(1);
    checkOutput("load0", 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 4'd0);
    stepClocks(4);
    checkOutput("dec_0to5", 4'd5, 1'b1, 1'b1);
    stepClocks(4);
    checkOutput("dec_5to4", 4'd4, 1'b1, 1'b0);

    // Load of an out-of-range value on the expiry cycle
    stepClocks(3);
    checkOutput("pre_load_expiry", 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b1, 4'd9);
    stepClocks(1);
    checkOutput("load9_clamp", 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 4'd9);
    stepClocks(3);
    checkOutput("after_load_idle", 4'd5, 1'b0, 1'b0);
    stepClocks(1);
    checkOutput("after_load_tick", 4'd4, 1'b1, 1'b0);

    // Enable gap mid-count, with noise on mode/load_val
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd0);
    stepClocks(2);
    applyStimulus(1'b0, 2'b11, 1'b0, 4'd7);
    stepClocks(10);
    checkOutput("en_off", 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd7);
    stepClocks(1);
    checkOutput("en_resume_idle", 4'd4, 1'b0, 1'b0);
    stepClocks(1);
    checkOutput("en_resume_tick", 4'd5, 1'b1, 1'b0);

    // Hold mode still ticks but never moves or wraps
    applyStimulus(1'b1, 2'b00, 1'b0, 4'd0);
    stepClocks(4);
    checkOutput("hold", 4'd5, 1'b1, 1'b0);

    // Asynchronous reset while tick is high at state 3
    applyStimulus(1'b1, 2'b01, 1'b1, 4'd2);
    stepClocks(1);
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd2);
    stepClocks(4);
    checkOutput("pre_reset", 4'd3, 1'b1, 1'b0);
    reset = 1'b0;
    #2;
    checkOutput("async_reset", 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 4'd1);
    stepClocks(1);
    checkOutput("reset_beats_load", 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 4'd0);
    reset = 1'b1;
    stepClocks(3);
    checkOutput("post_reset_idle", 4'd0, 1'b0, 1'b0);
    stepClocks(1);
    checkOutput("post_reset_tick", 4'd1, 1'b1, 1'b0);

    // Sixteen-state sweep through every segment pattern
    checkVal("sweep.reset_seg", {1'b0, seg16}, {1'b0, SEG_TABLE[0]});
    reset16 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      stepClocks(4);
      checkVal($sformatf("sweep%0d.state", k), {4'd0, state16}, 8'(k % 16));
      checkVal($sformatf("sweep%0d.seg", k), {1'b0, seg16}, {1'b0, SEG_TABLE[k % 16]});
      checkVal($sformatf("sweep%0d.wrap", k), {7'd0, wrap16}, {7'd0, (k == 16)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/moore_step_counter.md
MOORE_STEP_COUNTER -- requirements
Module: moore_step_counter

Interface
REQ-001 Parameter DIV, default 25000000: prescaler period in clk cycles, legal range 2..2^32-1.
REQ-002 Parameter MOD, default 6: number of FSM states, legal range 2..16.
REQ-003 Parameter STEP, default 3: jump size for mode 2'b10, legal range 1..MOD-1.
REQ-004 clk  input  1  system clock; all state is clocked on its rising edge; no derived clocks.
REQ-005 reset  input  1  asynchronous, active-low.
REQ-006 en  input  1  prescaler run enable.
REQ-007 mode  input  2  step mode: 00 hold, 01 +1, 10 +STEP, 11 -1.
REQ-008 load  input  1  synchronous state load strobe.
REQ-009 load_val  input  4  value to load.
REQ-010 state  output  4  current FSM state, registered, range 0..MOD-1.
REQ-011 seg  output  7  active-low seven-segment pattern of state, bit order seg[6]=a ... seg[0]=g.
REQ-012 tick  output  1  registered one-cycle pulse marking each prescaler expiry.
REQ-013 wrap  output  1  registered one-cycle pulse marking a modulo boundary crossing.

Function
REQ-014 The prescaler is a 32-bit count of 0..DIV-1; it increments each clk while en=1 and holds while en=0.
REQ-015 When count==DIV-1 and en=1, the count returns to 0 and tick is 1 for the next cycle only.
REQ-016 mode is sampled only in the cycle where the prescaler expires; the state update takes effect on that same edge, coincident with tick rising.
REQ-017 For mode 01, next state = (state+1) mod MOD.
REQ-018 For mode 10, next state = (state+STEP) mod MOD, computed in at least 5 bits with no overflow.
REQ-019 For mode 11, next state = state-1, or MOD-1 when state==0.
REQ-020 For mode 00, state is held and wrap stays 0.
REQ-021 wrap is 1 for exactly one cycle, coincident with tick, when an up step yields a result below the old state, or when a -1 step is taken from state 0.
REQ-022 load=1 has priority over any step: on the next edge, state = load_val, or MOD-1 if load_val >= MOD.
REQ-023 The same load edge clears the prescaler count to 0 and forces tick=0 and wrap=0.
REQ-024 A load coinciding with prescaler expiry suppresses that step entirely.
REQ-025 seg is a pure combinational (Moore) decode of the state register only; it never depends on mode, load or en directly.
REQ-026 Decode table (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
REQ-027 Decode table continued: 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-028 Changes on en, mode or load_val between expiries have no effect on state.

Reset
REQ-029 While reset=0, asynchronously: prescaler count=0, state=0, tick=0, wrap=0, seg=0000001.
REQ-030 Reset asserted mid-count or coincident with load or expiry overrides all other activity.
REQ-031 After reset deasserts, the first expiry occurs DIV enabled cycles later.

Verification (DIV=4, MOD=6, STEP=3 unless noted)
REQ-032 Reset release, en=1, mode=01 for 28 cycles -> tick every 4th cycle; state 1,2,3,4,5,0,1; wrap only on the 5->0 step; seg for 5 = 0100100.
REQ-033 From state 4, mode=10 -> state 1 with wrap=1; next expiry -> state 4 with wrap=0.
REQ-034 From state 0, mode=11 -> state 5 with wrap=1; next expiry -> state 4.
REQ-035 load=1 with load_val=9 at the cycle of expiry -> state=5, no step, tick=0, next tick exactly 4 cycles after load.
REQ-036 en=0 for 10 cycles mid-count, then en=1 -> no tick while disabled; expiry resumes after the remaining count.
REQ-037 reset pulsed low mid-operation at state 3 -> immediate state=0, seg=0000001, tick=0, wrap=0; MOD=16 sweep with mode=01 -> all 16 seg patterns in order.
